// File: rtl/bus_and_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_and_arbiter_if : requester/response bundle for bus_and_arbiter        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface bus_and_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             busy;

  // Environment side: requesters and response consumer.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/bus_and_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_and_arbiter : round-robin two-requester AND datapath, 1-entry slot    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bus_and_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  bus_and_arbiter_if.slave  bus
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic             last_q,     last_d;
  logic             id_q,       id_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             carry_q,    carry_d;
  logic             overflow_q, overflow_d;

  logic             grant0;
  logic             grant1;
  logic             slot_free;
  logic             accept0;
  logic             accept1;
  logic [WIDTH-1:0] operand_and;

  // Grant and accept; contention goes to the requester not served last.
  always_comb begin
    grant0      = bus.req0_valid && (!bus.req1_valid || last_q);
    grant1      = bus.req1_valid && (!bus.req0_valid || !last_q);
    slot_free   = (state_q == S_EMPTY) || bus.rsp_ready;
    accept0     = grant0 && slot_free && !rst;
    accept1     = grant1 && slot_free && !rst;
    operand_and = accept1 ? (bus.req1_a & bus.req1_b) : (bus.req0_a & bus.req0_b);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: an accept refills the slot even while it drains.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    if (accept0 || accept1) begin
      state_d    = S_FULL;
      last_d     = accept1;
      id_d       = accept1;
      result_d   = operand_and;
      carry_d    = operand_and[WIDTH-1] | operand_and[WIDTH-2];
      overflow_d = operand_and[WIDTH-1] & operand_and[WIDTH-2];
    end else if ((state_q == S_FULL) && bus.rsp_ready) begin
      state_d    = S_EMPTY;
    end
  end

  // Outputs
  always_comb begin
    bus.req0_ready   = accept0;
    bus.req1_ready   = accept1;
    bus.rsp_valid    = (state_q == S_FULL);
    bus.busy         = (state_q == S_FULL);
    bus.rsp_id       = id_q;
    bus.rsp_result   = result_q;
    bus.rsp_carry    = carry_q;
    bus.rsp_overflow = overflow_q;
  end

endmodule
`default_nettype wire

// File: doc/bus_and_arbiter.md
# bus_and_arbiter

Two-requester arbiter and sequencer for the shared 8-bit AND/register datapath. Each requester presents an operand pair under valid/ready. The block grants the datapath round-robin and computes `a & b` plus carry/overflow flags from the two result MSBs. It returns the registered result through a single-entry response slot tagged with the winning requester. It sits between operand producers and the consumer of `result`/`carry`/`overflow`, and replaces direct wiring to the datapath.

## Interface
- `WIDTH`, default 8: operand/result width; legal range ≥ 2, because the flags use bits WIDTH-1 and WIDTH-2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_valid`  in  1  requester 0 holds an operand pair.
- `req0_ready`  out  1  requester 0 pair accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0.
- `rsp_valid`  out  1  response slot holds a result.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_id`  out  1  requester that produced the held result.
- `rsp_result`  out  WIDTH  registered `a & b`.
- `rsp_carry`  out  1  `rsp_result[WIDTH-1] | rsp_result[WIDTH-2]`.
- `rsp_overflow`  out  1  `rsp_result[WIDTH-1] & rsp_result[WIDTH-2]`.
- `busy`  out  1  equals `rsp_valid`.

## Operation
- **State.** One-bit slot state with two values:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - Separate one-bit round-robin pointer `last` holds the id granted most recently.
- **Slot free.** `slot_free = !rsp_valid || rsp_ready`. This allows pass-through drain-and-refill in the same cycle.
- **Grant (combinational).**
  - Only one requester valid: that requester is granted.
  - Both valid: the requester ≠ `last` is granted.
  - Neither valid: no grant.
- **Ready.** `reqN_ready = grantN && slot_free && !rst`. At most one ready is high per cycle.
- **Accept.** Occurs when `reqN_valid && reqN_ready`. On the next edge:
  - `rsp_result` ← `reqN_a & reqN_b`
  - `rsp_id` ← N
  - carry/overflow loaded from the computed value
  - `rsp_valid` ← 1
  - `last` ← N
- **Drain.** `rsp_valid && rsp_ready` with no accept in the same cycle → `rsp_valid` ← 0. Data registers keep their last value.
- **Simultaneous drain + accept.** The slot reloads with the new result and stays FULL.
- **Pointer.** `last` changes only on accept. Idle cycles and backpressure do not rotate fairness.
- **Stability.** While `rsp_valid && !rsp_ready`, all `rsp_*` outputs are held stable.
- **Requester protocol.** A requester must hold valid and operands stable until ready. The block does not check this.
- **Reset.** While `rst`=1, both readies are 0. On the next edge:
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_carry`, `rsp_overflow` ← 0.
  - `last` ← 1, so requester 0 wins the first contended grant.
- **Reset mid-operation.** An undelivered response is discarded, with no replay. A requester that saw no ready must keep asserting valid.

## Timing
- Request accepted at edge N; result visible with `rsp_valid`=1 in cycle N+1. Latency is 1 cycle.
- Throughput is one result per cycle while `rsp_ready`=1.
- Contention with `rsp_ready`=1 held produces strict alternation 0,1,0,1…
- Worst-case wait for a continuously valid requester is one accepted transfer of the other requester plus any backpressure cycles.
- Combinational path: `req*_valid`/`rsp_ready` → `req*_ready`. There is no path from `req*_a`/`req*_b` to any output in the same cycle.
- `busy` is a registered output.

## Test plan
1. **Reset hold.** Hold `rst`=1 for 2 cycles with `req0_valid`=1, `a`=0xFF, `b`=0xFF.
   - During reset: `req0_ready`=0; all `rsp_*` = 0.
   - First cycle after release: `req0_ready`=1.
   - Next cycle: `rsp_result`=0xFF, `rsp_carry`=1, `rsp_overflow`=1, `rsp_id`=0.
2. **Single request.** req0 only, `a`=0xFF, `b`=0xC3, `rsp_ready`=1.
   - One cycle later: `rsp_valid`=1, `rsp_id`=0, `rsp_result`=0xC3, `rsp_carry`=1, `rsp_overflow`=1.
   - Following cycle with no request: `rsp_valid`=0.
3. **Contention.** req0 (`a`=0x0F, `b`=0xFF) and req1 (`a`=0x80, `b`=0x80) both continuously valid, `rsp_ready`=1.
   - Ids alternate 0,1,0,1.
   - Id 0 results: 0x0F, carry 0, overflow 0.
   - Id 1 results: 0x80, carry 1, overflow 0.
4. **Backpressure.** After the first response, hold `rsp_ready`=0 for 5 cycles with both requesters valid.
   - During the stall: both readies 0; `rsp_*` unchanged.
   - Raise `rsp_ready`: the loser of the last grant is accepted in that same cycle, and its result appears next cycle.
5. **Flag boundary.** req1 only, `a`=0x40, `b`=0x7F → `rsp_result`=0x40, `rsp_carry`=1, `rsp_overflow`=0, `rsp_id`=1.
6. **Reset mid-operation.** Assert `rst` for 1 cycle while `rsp_valid`=1 with `rsp_ready`=0.
   - Next cycle: `rsp_valid`=0, `busy`=0.
   - Next contended grant goes to req0 regardless of the previous pointer.
